systolic_os_sequencer: RTL and testbench

- Hardware control sequencer for systolic_system in output-stationary (OS) mode.
- Replaces hand-timed bench stimulus: from start, M, K, N it tiles the MxN output over the ARRAY_N x ARRAY_M array.
- For every tile it generates the FLOW / SKEW / DRAIN / STORE control sequence: a_buf_on, w_buf_on, operation_signal_in, o_ag_o_on, plus base addresses and tile sizes.
- Sits between the NPU command register block and systolic_system.

---
 rtl/systolic_os_sequencer_pkg.sv | 20 ++
 rtl/systolic_os_sequencer_if.sv | 44 ++++
 rtl/systolic_os_sequencer_tile.sv | 83 ++++++++
 rtl/systolic_os_sequencer.sv | 156 +++++++++++++++
 tb/tb_systolic_os_sequencer.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/systolic_os_sequencer_pkg.sv
// Shared definitions for the output-stationary systolic sequencer.
// Holds the operation codes driven onto operation_signal_in, the sequencer
// state encoding, and small integer helpers used for tile sizing.
package npu_seq_pkg;

  localparam logic [2:0] OP_IDLE  = 3'b000;
  localparam logic [2:0] OP_FLOW  = 3'b100;
  localparam logic [2:0] OP_DRAIN = 3'b110;

  typedef enum logic [2:0] {IDLE, FLOW, SKEW, DRAIN, STORE} state_t;

  function automatic int unsigned min_u(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction

  function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/systolic_os_sequencer_if.sv
// Bundle between the command register block, the sequencer and systolic_system.
// master: command/array side (drives start, abort, M, K, N; observes status
//         and the array control sequence).
// slave : the sequencer itself.
interface systolic_os_sequencer_if #(
  parameter int unsigned ARRAY_N    = 16,
  parameter int unsigned ARRAY_M    = 16,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DIM_WIDTH  = 16
);
  localparam int unsigned RW = $clog2(ARRAY_N) + 1;
  localparam int unsigned CW = $clog2(ARRAY_M) + 1;

  logic                  start;
  logic                  abort;
  logic [DIM_WIDTH-1:0]  M;
  logic [DIM_WIDTH-1:0]  K;
  logic [DIM_WIDTH-1:0]  N;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic                  a_buf_on;
  logic                  w_buf_on;
  logic                  mode;
  logic [2:0]            operation_signal_in;
  logic [ADDR_WIDTH-1:0] a_base_addr;
  logic [ADDR_WIDTH-1:0] w_base_addr;
  logic [ADDR_WIDTH-1:0] o_base_addr;
  logic [RW-1:0]         a_num_rows;
  logic [CW-1:0]         w_num_cols;
  logic                  o_ag_o_on;

  modport master (
    output start, abort, M, K, N,
    input  busy, done, err, a_buf_on, w_buf_on, mode, operation_signal_in,
           a_base_addr, w_base_addr, o_base_addr, a_num_rows, w_num_cols, o_ag_o_on
  );

  modport slave (
    input  start, abort, M, K, N,
    output busy, done, err, a_buf_on, w_buf_on, mode, operation_signal_in,
           a_base_addr, w_base_addr, o_base_addr, a_num_rows, w_num_cols, o_ag_o_on
  );
endinterface

// File: rtl/systolic_os_sequencer_tile.sv
// os_tile_counter: walks the output tiles (column tile first, then row tile)
// and keeps per-tile sizes and buffer base addresses in registers.
// Ports: clk, reset_n (async, active-low); load (start of a job, samples
// m_in/n_in), advance (step to next tile), clear (return to idle values);
// k = latched reduction length; rows/cols = current tile size;
// a_base/w_base/o_base = base addresses; last_tile = current tile is final.
module os_tile_counter
  import npu_seq_pkg::*;
#(
  parameter int unsigned ARRAY_N    = 16,
  parameter int unsigned ARRAY_M    = 16,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DIM_WIDTH  = 16,
  parameter int unsigned RW         = $clog2(ARRAY_N) + 1,
  parameter int unsigned CW         = $clog2(ARRAY_M) + 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  load,
  input  logic                  advance,
  input  logic                  clear,
  input  logic [DIM_WIDTH-1:0]  m_in,
  input  logic [DIM_WIDTH-1:0]  n_in,
  input  logic [DIM_WIDTH-1:0]  k,
  output logic [RW-1:0]         rows,
  output logic [CW-1:0]         cols,
  output logic [ADDR_WIDTH-1:0] a_base,
  output logic [ADDR_WIDTH-1:0] w_base,
  output logic [ADDR_WIDTH-1:0] o_base,
  output logic                  last_tile
);

  logic [DIM_WIDTH-1:0] row_tile, col_tile, tile_idx;
  logic [DIM_WIDTH-1:0] last_row, last_col;
  // Remaining rows/cols from the current tile origin to the matrix edge.
  logic [DIM_WIDTH-1:0] row_rem, col_rem, n_lat;

  assign last_tile = (row_tile == last_row) && (col_tile == last_col);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      {row_tile, col_tile, tile_idx, last_row, last_col, row_rem, col_rem, n_lat} <= '0;
      {rows, cols, a_base, w_base, o_base} <= '0;
    end else if (clear) begin
      {row_tile, col_tile, tile_idx, last_row, last_col, row_rem, col_rem, n_lat} <= '0;
      {rows, cols, a_base, w_base, o_base} <= '0;
    end else if (load) begin
      row_tile <= '0;
      col_tile <= '0;
      tile_idx <= '0;
      last_row <= DIM_WIDTH'(ceil_div(32'(m_in), ARRAY_N) - 1);
      last_col <= DIM_WIDTH'(ceil_div(32'(n_in), ARRAY_M) - 1);
      row_rem  <= m_in;
      col_rem  <= n_in;
      n_lat    <= n_in;
      rows     <= RW'(min_u(ARRAY_N, 32'(m_in)));
      cols     <= CW'(min_u(ARRAY_M, 32'(n_in)));
      a_base   <= '0;
      w_base   <= '0;
      o_base   <= '0;
    end else if (advance) begin
      tile_idx <= tile_idx + DIM_WIDTH'(1);
      o_base   <= ADDR_WIDTH'((32'(tile_idx) + 32'd1) * ARRAY_N);
      if (col_tile != last_col) begin
        col_tile <= col_tile + DIM_WIDTH'(1);
        col_rem  <= col_rem - DIM_WIDTH'(ARRAY_M);
        w_base   <= w_base + ADDR_WIDTH'(k);
        cols     <= CW'(min_u(ARRAY_M, 32'(col_rem) - ARRAY_M));
      end else begin
        // Column wrap: restart the column walk and move down one row tile.
        col_tile <= '0;
        col_rem  <= n_lat;
        w_base   <= '0;
        cols     <= CW'(min_u(ARRAY_M, 32'(n_lat)));
        row_tile <= row_tile + DIM_WIDTH'(1);
        row_rem  <= row_rem - DIM_WIDTH'(ARRAY_N);
        a_base   <= a_base + ADDR_WIDTH'(k);
        rows     <= RW'(min_u(ARRAY_N, 32'(row_rem) - ARRAY_N));
      end
    end
  end

endmodule

// File: rtl/systolic_os_sequencer.sv
// systolic_os_sequencer: control sequencer for systolic_system in
// output-stationary mode. From start/M/K/N it tiles the MxN output and, per
// tile, plays FLOW (K) -> SKEW (rows+cols-1) -> DRAIN (ARRAY_N-rows-1, may be
// empty) -> STORE (rows+1) with no bubbles between phases.
// Ports: clk, reset_n (async, active-low); bus (slave modport) carrying the
// command inputs, status (busy/done/err) and array controls, all registered.
module systolic_os_sequencer
  import npu_seq_pkg::*;
#(
  parameter int unsigned ARRAY_N    = 16,
  parameter int unsigned ARRAY_M    = 16,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DIM_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  systolic_os_sequencer_if.slave  bus
);

  localparam int unsigned RW    = $clog2(ARRAY_N) + 1;
  localparam int unsigned CW    = $clog2(ARRAY_M) + 1;
  localparam int unsigned CNT_W = DIM_WIDTH + 1;

  state_t               state, state_nx;
  logic [CNT_W-1:0]     cnt, cnt_nx;
  logic [DIM_WIDTH-1:0] k_lat;
  logic                 load, advance, clear;
  logic                 busy_nx, done_nx, err_nx, buf_on_nx, ag_on_nx;
  logic [2:0]           op_nx;
  logic [RW-1:0]        rows;
  logic [CW-1:0]        cols;
  logic                 last_tile;
  logic [CNT_W-1:0]     skew_len, drain_len;

  os_tile_counter #(
    .ARRAY_N(ARRAY_N), .ARRAY_M(ARRAY_M), .ADDR_WIDTH(ADDR_WIDTH), .DIM_WIDTH(DIM_WIDTH)
  ) u_tile (
    .clk(clk), .reset_n(reset_n), .load(load), .advance(advance), .clear(clear),
    .m_in(bus.M), .n_in(bus.N), .k(k_lat),
    .rows(rows), .cols(cols),
    .a_base(bus.a_base_addr), .w_base(bus.w_base_addr), .o_base(bus.o_base_addr),
    .last_tile(last_tile)
  );

  assign bus.a_num_rows = rows;
  assign bus.w_num_cols = cols;
  assign bus.mode       = 1'b1;

  assign skew_len  = CNT_W'(rows) + CNT_W'(cols) - CNT_W'(1);
  // Partial-height tiles need the remaining array rows flushed before STORE.
  assign drain_len = (CNT_W'(rows) + CNT_W'(1) < CNT_W'(ARRAY_N))
                   ? CNT_W'(ARRAY_N) - CNT_W'(rows) - CNT_W'(1) : '0;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    load     = 1'b0;
    advance  = 1'b0;
    clear    = 1'b0;
    done_nx  = 1'b0;
    err_nx   = 1'b0;
    if (state == IDLE) begin
      if (bus.start && !bus.abort) begin
        if (bus.M == '0 || bus.K == '0 || bus.N == '0) begin
          err_nx = 1'b1;
        end else begin
          state_nx = FLOW;
          cnt_nx   = CNT_W'(bus.K) - CNT_W'(1);
          load     = 1'b1;
        end
      end
    end else if (bus.abort) begin
      state_nx = IDLE;
      cnt_nx   = '0;
      clear    = 1'b1;
    end else if (cnt != '0) begin
      cnt_nx = cnt - CNT_W'(1);
    end else begin
      // Phase counter expired: reload for the following phase.
      unique case (state)
        FLOW: begin
          state_nx = SKEW;
          cnt_nx   = skew_len - CNT_W'(1);
        end
        SKEW: begin
          if (drain_len != '0) begin
            state_nx = DRAIN;
            cnt_nx   = drain_len - CNT_W'(1);
          end else begin
            state_nx = STORE;
            cnt_nx   = CNT_W'(rows);
          end
        end
        DRAIN: begin
          state_nx = STORE;
          cnt_nx   = CNT_W'(rows);
        end
        STORE: begin
          if (last_tile) begin
            state_nx = IDLE;
            cnt_nx   = '0;
            done_nx  = 1'b1;
            clear    = 1'b1;
          end else begin
            state_nx = FLOW;
            cnt_nx   = CNT_W'(k_lat) - CNT_W'(1);
            advance  = 1'b1;
          end
        end
        default: begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end
      endcase
    end

    buf_on_nx = 1'b0;
    ag_on_nx  = 1'b0;
    op_nx     = OP_IDLE;
    unique case (state_nx)
      FLOW:    begin buf_on_nx = 1'b1; op_nx = OP_FLOW; end
      SKEW:    op_nx = OP_FLOW;
      DRAIN:   op_nx = OP_DRAIN;
      STORE:   begin ag_on_nx = 1'b1; op_nx = OP_DRAIN; end
      default: op_nx = OP_IDLE;
    endcase
    busy_nx = (state_nx != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state                   <= IDLE;
      cnt                     <= '0;
      k_lat                   <= '0;
      bus.busy                <= 1'b0;
      bus.done                <= 1'b0;
      bus.err                 <= 1'b0;
      bus.a_buf_on            <= 1'b0;
      bus.w_buf_on            <= 1'b0;
      bus.o_ag_o_on           <= 1'b0;
      bus.operation_signal_in <= OP_IDLE;
    end else begin
      state                   <= state_nx;
      cnt                     <= cnt_nx;
      if (load) k_lat         <= bus.K;
      bus.busy                <= busy_nx;
      bus.done                <= done_nx;
      bus.err                 <= err_nx;
      bus.a_buf_on            <= buf_on_nx;
      bus.w_buf_on            <= buf_on_nx;
      bus.o_ag_o_on           <= ag_on_nx;
      bus.operation_signal_in <= op_nx;
    end
  end

endmodule

// File: tb/tb_systolic_os_sequencer.sv
// Directed bench for systolic_os_sequencer: single and multi-tile jobs,
// zero-dimension rejection, start while busy, abort, and async reset mid-job.
module tb_systolic_os_sequencer;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  systolic_os_sequencer_if bus ();

  systolic_os_sequencer dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  // {busy, done, err, a_buf_on, w_buf_on, o_ag_o_on, op[2:0]}
  localparam logic [8:0] V_IDLE  = 9'b000_000_000;
  localparam logic [8:0] V_FLOW  = 9'b100_110_100;
  localparam logic [8:0] V_SKEW  = 9'b100_000_100;
  localparam logic [8:0] V_DRAIN = 9'b100_000_110;
  localparam logic [8:0] V_STORE = 9'b100_001_110;
  localparam logic [8:0] V_DONE  = 9'b010_000_000;
  localparam logic [8:0] V_ERR   = 9'b001_000_000;

  logic [8:0] ctl;
  assign ctl = {bus.busy, bus.done, bus.err, bus.a_buf_on, bus.w_buf_on,
                bus.o_ag_o_on, bus.operation_signal_in};

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_cmd(input int m, input int k, input int n);
    bus.M     = 16'(m);
    bus.K     = 16'(k);
    bus.N     = 16'(n);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  // Called on the first FLOW cycle of a tile; consumes the whole tile.
  // poke >= 0 pulses start (with different dimensions) on that tile cycle.
  task automatic run_tile(input string tag, input int fl, input int sk, input int dr,
                          input int st, input int rows, input int cols, input int ab,
                          input int wb, input int ob, input int poke);
    logic [8:0] e;
    chk({tag, ".rows"},   64'(bus.a_num_rows),  64'(rows));
    chk({tag, ".cols"},   64'(bus.w_num_cols),  64'(cols));
    chk({tag, ".a_base"}, 64'(bus.a_base_addr), 64'(ab));
    chk({tag, ".w_base"}, 64'(bus.w_base_addr), 64'(wb));
    chk({tag, ".o_base"}, 64'(bus.o_base_addr), 64'(ob));
    for (int i = 0; i < fl + sk + dr + st; i++) begin
      if (i < fl)                e = V_FLOW;
      else if (i < fl + sk)      e = V_SKEW;
      else if (i < fl + sk + dr) e = V_DRAIN;
      else                       e = V_STORE;
      chk($sformatf("%s.cyc%0d", tag, i), 64'(ctl), 64'(e));
      if (i == poke) begin
        bus.start = 1'b1;
        bus.M = 16'd1;
        bus.K = 16'd1;
        bus.N = 16'd1;
      end else begin
        bus.start = 1'b0;
      end
      step();
    end
    bus.start = 1'b0;
  endtask

  task automatic finish_job(input string tag);
    chk({tag, ".done"}, 64'(ctl), 64'(V_DONE));
    chk({tag, ".rows0"}, 64'(bus.a_num_rows), 64'd0);
    step();
    chk({tag, ".idle"}, 64'(ctl), 64'(V_IDLE));
  endtask

  initial begin
    reset_n   = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.M     = '0;
    bus.K     = '0;
    bus.N     = '0;
    step();
    step();
    chk("reset.ctl",    64'(ctl),             64'(V_IDLE));
    chk("reset.mode",   64'(bus.mode),        64'd1);
    chk("reset.rows",   64'(bus.a_num_rows),  64'd0);
    chk("reset.cols",   64'(bus.w_num_cols),  64'd0);
    chk("reset.o_base", 64'(bus.o_base_addr), 64'd0);
    reset_n = 1'b1;
    step();

    // Full 16x16 tile: FLOW 30, SKEW 31, no DRAIN, STORE 17, done at cycle 79.
    start_cmd(16, 30, 16);
    run_tile("full", 30, 31, 0, 17, 16, 16, 0, 0, 0, -1);
    finish_job("full");

    // 6x6 tile with a start pulse mid-run and changed dims; must not disturb.
    start_cmd(6, 30, 6);
    run_tile("small", 30, 11, 9, 7, 6, 6, 0, 0, 0, 20);
    finish_job("small");

    // Two row tiles: 16 rows then 4 rows.
    start_cmd(20, 8, 16);
    run_tile("rowt0", 8, 31, 0, 17, 16, 16, 0, 0, 0, -1);
    run_tile("rowt1", 8, 19, 11, 5, 4, 16, 8, 0, 16, -1);
    finish_job("rowt");

    // Two column tiles: 16 cols then 4 cols.
    start_cmd(16, 4, 20);
    run_tile("colt0", 4, 31, 0, 17, 16, 16, 0, 0, 0, -1);
    run_tile("colt1", 4, 19, 0, 17, 16, 4, 0, 4, 16, -1);
    finish_job("colt");

    // Zero K is rejected.
    start_cmd(5, 0, 5);
    chk("zero_k.err", 64'(ctl), 64'(V_ERR));
    step();
    chk("zero_k.after", 64'(ctl), 64'(V_IDLE));

    // start and abort together in idle: start dropped.
    bus.abort = 1'b1;
    start_cmd(16, 30, 16);
    bus.abort = 1'b0;
    chk("abort_start.idle", 64'(ctl), 64'(V_IDLE));
    step();
    chk("abort_start.idle2", 64'(ctl), 64'(V_IDLE));

    // Abort on FLOW cycle 5.
    start_cmd(16, 30, 16);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("abort.flow%0d", i), 64'(ctl), 64'(V_FLOW));
      if (i < 4) step();
    end
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("abort.idle%0d", i), 64'(ctl), 64'(V_IDLE));
      step();
    end
    start_cmd(16, 30, 16);
    run_tile("reaborted", 30, 31, 0, 17, 16, 16, 0, 0, 0, -1);
    finish_job("reaborted");

    // Asynchronous reset in SKEW.
    start_cmd(6, 4, 6);
    for (int i = 0; i < 6; i++) step();
    chk("rst.skew", 64'(ctl), 64'(V_SKEW));
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst.async_ctl",  64'(ctl),            64'(V_IDLE));
    chk("rst.async_mode", 64'(bus.mode),       64'd1);
    chk("rst.async_rows", 64'(bus.a_num_rows), 64'd0);
    step();
    reset_n = 1'b1;
    step();
    chk("rst.released", 64'(ctl), 64'(V_IDLE));
    start_cmd(6, 4, 6);
    run_tile("post_rst", 4, 11, 9, 7, 6, 6, 0, 0, 0, -1);
    finish_job("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
